// File: rtl/div_seq_if.sv
// Divider request/response bundle; the pipeline side drives operands and the divider
// returns stall, a one-cycle ready pulse and the {remainder, quotient} result.
interface div_seq_if;
    logic        start;
    logic        annul;
    logic        sign;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        stall;
    logic        ready;
    logic [63:0] result;

    modport master (
        output start, annul, sign, opa, opb,
        input  stall, ready, result
    );

    modport slave (
        input  start, annul, sign, opa, opb,
        output stall, ready, result
    );
endinterface

// File: rtl/div_seq.sv
// Iterative 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
// Latency: ready 33 cycles after acceptance (2 cycles for divide by zero).
// Backpressure: none accepted; stall holds the pipeline while a divide is pending.
module div_seq (
    input  logic       clk,
    input  logic       rst,
    div_seq_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DZERO, DONE} state_t;

    state_t      state;
    state_t      stateNext;
    logic [4:0]  cnt;
    logic [31:0] remReg;
    logic [31:0] quoReg;
    logic [31:0] divisor;
    logic [31:0] opaLat;
    logic        negQuo;
    logic        negRem;
    logic [63:0] resultReg;

    logic        accept;
    logic [32:0] remShift;
    logic [32:0] diff;
    logic        geq;
    logic [31:0] remIter;
    logic [31:0] quoIter;
    logic [31:0] quoFinal;
    logic [31:0] remFinal;

    assign accept = (state == IDLE) && bus.start && !bus.annul;

    // Remainder stays below the divisor, so the 33-bit difference never wraps
    // and its top bit is a valid sign for the trial subtraction.
    always_comb begin
        remShift = {remReg, quoReg[31]};
        diff     = remShift - {1'b0, divisor};
        geq      = ~diff[32];
        remIter  = geq ? diff[31:0] : remShift[31:0];
        quoIter  = {quoReg[30:0], geq};
        quoFinal = negQuo ? (~quoIter + 32'd1) : quoIter;
        remFinal = negRem ? (~remIter + 32'd1) : remIter;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = (bus.opb == 32'd0) ? DZERO : BUSY;
                end
            end
            BUSY: begin
                if (bus.annul) begin
                    stateNext = IDLE;
                end else if (cnt == 5'd31) begin
                    stateNext = DONE;
                end
            end
            DZERO: begin
                stateNext = bus.annul ? IDLE : DONE;
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            remReg    <= 32'd0;
            quoReg    <= 32'd0;
            divisor   <= 32'd0;
            opaLat    <= 32'd0;
            negQuo    <= 1'b0;
            negRem    <= 1'b0;
            resultReg <= 64'd0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (accept) begin
                        opaLat  <= bus.opa;
                        divisor <= (bus.sign && bus.opb[31]) ? (~bus.opb + 32'd1) : bus.opb;
                        quoReg  <= (bus.sign && bus.opa[31]) ? (~bus.opa + 32'd1) : bus.opa;
                        remReg  <= 32'd0;
                        cnt     <= 5'd0;
                        negQuo  <= bus.sign && (bus.opa[31] ^ bus.opb[31]);
                        negRem  <= bus.sign && bus.opa[31];
                    end
                end
                BUSY: begin
                    if (!bus.annul) begin
                        remReg <= remIter;
                        quoReg <= quoIter;
                        cnt    <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            resultReg <= {remFinal, quoFinal};
                        end
                    end
                end
                DZERO: begin
                    if (!bus.annul) begin
                        resultReg <= {opaLat, 32'hFFFF_FFFF};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.stall = 1'b0;
        case (state)
            IDLE:    bus.stall = bus.start && !bus.annul;
            BUSY:    bus.stall = 1'b1;
            DZERO:   bus.stall = 1'b1;
            default: bus.stall = 1'b0;
        endcase
        // IDLE stall follows start combinationally, so reset must mask it
        if (!rst) begin
            bus.stall = 1'b0;
        end
    end

    assign bus.ready  = (state == DONE);
    assign bus.result = resultReg;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: arithmetic reference model, directed corner cases,
// annul/reset scenarios and randomized back-to-back divides.
module tb_div_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    div_seq_if bus ();

    div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          nChecks    = 0;
    int          nFail      = 0;
    int          readyCount = 0;
    logic [63:0] sbq[$];
    logic [63:0] lastExp    = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint unsigned am, bm, q, r;
        logic [31:0] q32, r32;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        am  = (s && a[31]) ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
        bm  = (s && b[31]) ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
        q   = am / bm;
        r   = am % bm;
        q32 = q[31:0];
        r32 = r[31:0];
        if (s && (a[31] ^ b[31])) q32 = -q32;
        if (s && a[31])           r32 = -r32;
        return {r32, q32};
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.ready === 1'b1) begin
            readyCount++;
            if (sbq.size() == 0) begin
                nChecks++;
                nFail++;
                $display("FAIL unexpected_ready: got result %h expected no ready at %0t", bus.result, $time);
            end else begin
                chk("result", bus.result, sbq.pop_front());
            end
        end
    end

    // annulAt: cycle offset after acceptance at which annul is pulsed (-1 = never).
    task automatic runDiv(input logic [31:0] a, input logic [31:0] b, input logic s, input int annulAt);
        logic [63:0] e;
        int expLat, lat, rcBefore;
        bit seen, stallOk, aborted;
        expLat  = (b == 32'd0) ? 2 : 33;
        aborted = (annulAt >= 1) && (annulAt < expLat);
        e       = refDiv(a, b, s);
        @(negedge clk);
        bus.start = 1'b1; bus.annul = 1'b0;
        bus.opa = a; bus.opb = b; bus.sign = s;
        if (!aborted) sbq.push_back(e);
        #1 chk("stall_accept", 64'(bus.stall), 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.opa = $urandom; bus.opb = $urandom; bus.sign = 1'($urandom_range(0, 1));
        lat = 1; seen = 0; stallOk = 1;
        rcBefore = readyCount;
        if (aborted) begin
            while (lat < annulAt) begin
                if (bus.stall !== 1'b1 || bus.ready !== 1'b0) stallOk = 0;
                @(negedge clk);
                lat++;
            end
            bus.annul = 1'b1;
            @(negedge clk);
            bus.annul = 1'b0;
            chk("stall_before_annul", 64'(stallOk), 64'd1);
            chk("annul_idle", {62'd0, bus.stall, bus.ready}, 64'd0);
            chk("annul_no_ready", 64'(readyCount), 64'(rcBefore));
        end else begin
            while (!seen && lat <= 40) begin
                bus.annul = (lat == annulAt);
                if (bus.ready === 1'b1) begin
                    seen = 1;
                    chk("stall_done", 64'(bus.stall), 64'd0);
                end else begin
                    if (bus.stall !== 1'b1) stallOk = 0;
                    @(negedge clk);
                    lat++;
                end
            end
            bus.annul = 1'b0;
            chk("latency", 64'(lat), 64'(expLat));
            chk("stall_busy", 64'(stallOk), 64'd1);
            lastExp = e;
        end
    endtask

    initial begin
        int rcBefore;
        logic [31:0] a, b;
        logic s;
        int annulAt;

        bus.start = 1'b1; bus.annul = 1'b0; bus.sign = 1'b0;
        bus.opa = 32'd5; bus.opb = 32'd3;
        #1;
        chk("reset_state", {bus.result, bus.stall, bus.ready} , {64'd0, 2'b00});
        repeat (3) @(negedge clk);
        chk("reset_hold", {62'd0, bus.stall, bus.ready}, 64'd0);
        bus.start = 1'b0;
        rst = 1'b1;

        runDiv(32'd100, 32'd7, 1'b0, -1);
        chk("unsigned_100_7", bus.result, {32'd2, 32'd14});
        runDiv(32'hFFFF_FFF9, 32'd2, 1'b1, -1);
        runDiv(32'h1234_5678, 32'd0, 1'b1, -1);
        runDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1);
        chk("overflow_wrap", bus.result, {32'd0, 32'h8000_0000});
        runDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);

        // Annul mid-BUSY, restart two cycles later, then annul in DZERO and in DONE.
        runDiv(32'd1000, 32'd9, 1'b0, 10);
        runDiv(32'd9, 32'd3, 1'b0, -1);
        chk("after_annul_9_3", bus.result, {32'd0, 32'd3});
        runDiv(32'd77, 32'd0, 1'b0, 1);
        runDiv(32'hDEAD_BEEF, 32'd0, 1'b0, 2);
        runDiv(32'hFFFF_FF00, 32'd13, 1'b1, 33);

        // start with annul in IDLE is not accepted; result holds.
        @(negedge clk);
        bus.start = 1'b1; bus.annul = 1'b1; bus.opa = 32'd50; bus.opb = 32'd5;
        rcBefore = readyCount;
        #1 chk("start_annul_stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.start = 1'b0; bus.annul = 1'b0;
        repeat (40) @(negedge clk);
        chk("start_annul_no_ready", 64'(readyCount), 64'(rcBefore));
        chk("result_hold", bus.result, lastExp);

        // Asynchronous reset five cycles into a divide.
        @(negedge clk);
        bus.start = 1'b1; bus.opa = 32'd123456; bus.opb = 32'd77; bus.sign = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("async_reset", {bus.result, bus.stall, bus.ready}, {64'd0, 2'b00});
        rcBefore = readyCount;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("reset_no_ready", 64'(readyCount), 64'(rcBefore));
        runDiv(32'd1000, 32'd10, 1'b0, -1);

        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'd1;
                3:       b = $urandom_range(1, 15);
                4:       begin a = 32'h8000_0000; b = $urandom; end
                5:       begin a = $urandom_range(0, 200); b = $urandom_range(1, 300); end
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0:       annulAt = $urandom_range(1, 33);
                default: annulAt = -1;
            endcase
            runDiv(a, b, s, annulAt);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameters: none; operand width is fixed at 32 bits, and the 32 iteration cycles are fixed.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 start  input  1  request to begin a divide using opa/opb/sign this cycle.
REQ-005 annul  input  1  abort the divide in progress; no result is produced.
REQ-006 sign  input  1  1 = signed (div), 0 = unsigned (divu).
REQ-007 opa  input  32  dividend.
REQ-008 opb  input  32  divisor.
REQ-009 stall  output  1  pipeline hold request while a divide is pending.
REQ-010 ready  output  1  one-cycle pulse; result is valid this cycle.
REQ-011 result  output  64  {remainder[31:0] (to HI), quotient[31:0] (to LO)}.

Function
REQ-012 The block SHALL have four states: IDLE, BUSY, DZERO and DONE.
REQ-013 Transitions out of IDLE:
- IDLE with start=1, annul=0 and opb!=0 -> BUSY.
- IDLE with start=1, annul=0 and opb==0 -> DZERO.
- Otherwise the block stays in IDLE.
REQ-014 On acceptance from IDLE, the block SHALL latch opa, opb and sign, and clear the iteration counter to 0.
REQ-015 BUSY SHALL perform one restoring-division iteration per cycle on the operand magnitudes:
- Each iteration shifts the {rem, quo} register left by 1.
- It then trial-subtracts |opb| (33-bit compare).
- The quotient bit is set when the difference is non-negative.
REQ-016 BUSY SHALL last exactly 32 cycles (counter 0..31); at counter==31 it moves to DONE.
REQ-017 DZERO SHALL last 1 cycle, then move to DONE with quotient=32'hFFFF_FFFF and remainder=latched opa, regardless of sign.
REQ-018 DONE SHALL last 1 cycle, with ready=1 and result valid; it then moves to IDLE.
REQ-019 Latency: for a start accepted at cycle N, ready=1 at cycle N+33 for a normal divide and at cycle N+2 for a divide by zero.
REQ-020 Signed mode:
- Operands are converted to magnitudes before iterating.
- The quotient is negated when opa[31]^opb[31].
- The remainder takes the sign of opa.
- Sign correction is applied when entering DONE.
REQ-021 Signed 32'h8000_0000 / 32'hFFFF_FFFF SHALL give quotient 32'h8000_0000 and remainder 0 (two's-complement wrap, no trap).
REQ-022 stall SHALL be combinational:
- stall=1 in IDLE when start=1 and annul=0.
- stall=1 in BUSY and in DZERO.
- stall=0 in DONE and otherwise.
REQ-023 start is ignored in BUSY, DZERO and DONE; opa, opb and sign changes after acceptance have no effect on the result.
REQ-024 annul=1 in BUSY or DZERO SHALL force the next state to IDLE, with no ready pulse and result unchanged.
REQ-025 annul=1 in DONE SHALL be ignored: ready still pulses.
REQ-026 start=1 and annul=1 in the same IDLE cycle: annul wins and the divide is not accepted.
REQ-027 result SHALL hold its last value outside DONE and update only on entry to DONE.
REQ-028 A start in the cycle immediately after DONE (that is, in IDLE) SHALL be accepted; back-to-back divides therefore have one idle gap.

Reset
REQ-029 rst=0 SHALL asynchronously force:
- state to IDLE;
- the counter, all internal registers and result to 0;
- ready to 0 and stall to 0.
REQ-030 Reset asserted mid-BUSY SHALL abandon the divide with no ready pulse; after release the block accepts a new start normally.
REQ-031 Deassertion of rst SHALL take effect at the next rising edge of clk; no transition occurs during reset.

Verification
REQ-032 Unsigned divide:
- Stimulus: opa=100, opb=7, sign=0, start pulsed at cycle N.
- Response: ready at N+33, result={32'd2, 32'd14}, and stall high from N through N+32.
REQ-033 Signed divide:
- Stimulus: opa=-7 (32'hFFFF_FFF9), opb=2, sign=1.
- Response: quotient 32'hFFFF_FFFD (-3) and remainder 32'hFFFF_FFFF (-1).
REQ-034 Divide by zero:
- Stimulus: opa=32'h1234_5678, opb=0, start at N.
- Response: ready at N+2, result={32'h1234_5678, 32'hFFFF_FFFF}.
REQ-035 Overflow case:
- Stimulus: signed opa=32'h8000_0000, opb=32'hFFFF_FFFF.
- Response: result={0, 32'h8000_0000}.
REQ-036 Annul:
- Stimulus: start at N, annul at N+10.
- Response: IDLE at N+11, stall=0 and no ready pulse; a new start at N+12 (opa=9, opb=3) gives ready at N+45 with quotient 3 and remainder 0.
REQ-037 Reset:
- Stimulus: rst driven low at N+5 of a divide, asynchronous to clk.
- Response: stall, ready and result go to 0 immediately, and no ready pulse follows after release.
